// File: rtl/types_pkg.sv
// Shared types for the front end: the fetch buffer entry and fetch constants.
package types_pkg;

    // One buffered fetch result: the instruction word tagged with its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FETCH_PC_STEP  = 32'd4;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetch_data entries. Entry 0 is always the head; a pop
// shifts the survivors down, and a push lands just past them, so push and pop
// in the same cycle leave the count unchanged. Flush empties the buffer.
module fetch_fifo
    import types_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_data        push_data,
    input  logic             pop,
    output fetch_data        head,
    output logic [CNT_W-1:0] count
);

    fetch_data        mem_q [DEPTH];
    fetch_data        mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    // Next contents: flush wins, otherwise pop (shift) then push (append).
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            if (pop && (count_q != '0)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                count_d = count_q - 1'b1;
            end
            if (push && (count_d < CNT_W'(DEPTH))) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == count_d) begin
                        mem_d[i] = push_data;
                    end
                end
                count_d = count_d + 1'b1;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // An empty buffer presents an all-zero head.
    assign head  = (count_q != '0) ? mem_q[0] : '0;
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end. Issues one word-aligned read per cycle while
// the buffer has room for the result, tags returning data with its PC and
// hands it to decode in order.
// Handshake: an instruction transfers to decode on a rising edge where
// valid_out && ready_out; while valid_out=1 and ready_out=0, instr/pc_out hold.
module fetch_unit
    import types_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [31:0] instr,
    output logic [31:0] pc_out
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] occupancy;
    logic [7:0]       demand;
    logic             push, pop, flush;
    fetch_data        head, push_data;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (occupancy)
    );

    // Buffer head drives decode; reset masks the outputs while it is held.
    assign valid_out = !reset && (occupancy != '0);
    assign instr     = reset ? '0 : head.instr;
    assign pc_out    = reset ? '0 : head.pc;
    assign imem_addr = word_align(fetch_pc_q);

    // Request gating, buffer write of the returning word, and next fetch PC.
    always_comb begin
        pop            = valid_out && ready_out;
        // Slots already claimed after this cycle's pop: buffered plus in flight.
        demand         = 8'(occupancy) + 8'(inflight_q) - 8'(pop);
        imem_req       = !reset && !redirect_valid && (demand < 8'(BUF_DEPTH));
        push           = inflight_q && !reset && !redirect_valid;
        push_data.pc   = inflight_pc_q;
        push_data.instr = imem_rdata;
        flush          = redirect_valid;
        inflight_d     = imem_req;
        inflight_pc_d  = inflight_pc_q;
        fetch_pc_d     = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
        end else if (imem_req) begin
            // 32-bit add wraps 32'hFFFF_FFFC to 32'h0.
            fetch_pc_d    = fetch_pc_q + FETCH_PC_STEP;
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch PC and in-flight tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule
